// File: rtl/elem_stream_checker.sv
// elem_stream_checker
// Receiving end of an element valid/ready stream. The block accepts elements,
// compares each one with an expected incrementing sequence, and counts the
// received elements and the mismatches. It can throttle ready with an LFSR
// pattern so that the source sees back-pressure.
//
// Parameters:
//   ELEM_WIDTH - element width in bits
//   CNT_WIDTH  - width of the length, received-count and error-count fields
//   LFSR_SEED  - reset value of the throttle LFSR (a value of 0 becomes 8'h01)
//
// Ports:
//   clk_i           - single clock; all logic runs on its rising edge
//   srst_i          - synchronous active-high reset
//   elem_i          - incoming element
//   elem_valid_i    - element valid
//   elem_ready_o    - checker ready to accept
//   start_i         - one-cycle pulse that begins a run (ignored while running)
//   stop_i          - one-cycle pulse that aborts a run
//   throttle_en_i   - 1: ready follows lfsr[0]; 0: ready is held high in RUN
//   exp_seed_i      - first expected element, sampled on start
//   len_i           - number of elements per run, sampled on start (0 = unbounded)
//   rx_count_o      - accepted-element count (saturating)
//   err_count_o     - mismatch count (saturating)
//   err_o           - sticky mismatch flag for the current run
//   first_err_got_o - received value at the first mismatch
//   first_err_exp_o - expected value at the first mismatch
//   busy_o          - high while in RUN
//   done_o          - high while in DONE
module elem_stream_checker #(
    parameter int unsigned ELEM_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [ELEM_WIDTH-1:0] elem_i,
    input  logic                  elem_valid_i,
    output logic                  elem_ready_o,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  throttle_en_i,
    input  logic [ELEM_WIDTH-1:0] exp_seed_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    output logic [CNT_WIDTH-1:0]  rx_count_o,
    output logic [CNT_WIDTH-1:0]  err_count_o,
    output logic                  err_o,
    output logic [ELEM_WIDTH-1:0] first_err_got_o,
    output logic [ELEM_WIDTH-1:0] first_err_exp_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [7:0] LFSR_INIT = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ELEM_WIDTH-1:0] ELEM_ONE = {{(ELEM_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic                    start_load;
    logic [7:0]              lfsr_q;
    logic                    lfsr_fb;
    logic [ELEM_WIDTH-1:0]   exp_q;
    logic [CNT_WIDTH-1:0]    len_q;
    logic [CNT_WIDTH-1:0]    rx_q;
    logic [CNT_WIDTH-1:0]    rx_inc;
    logic [CNT_WIDTH-1:0]    errc_q;
    logic [CNT_WIDTH-1:0]    errc_inc;
    logic                    err_q;
    logic [ELEM_WIDTH-1:0]   fgot_q;
    logic [ELEM_WIDTH-1:0]   fexp_q;
    logic                    hs;
    logic                    mismatch;
    logic                    last_hs;

    // Ready uses only the registered state, the LFSR and the throttle
    // enable, so it never depends on valid.
    always_comb begin
        elem_ready_o = (state_q == ST_RUN) & (throttle_en_i ? lfsr_q[0] : 1'b1);
    end

    always_comb begin
        hs       = elem_valid_i & elem_ready_o;
        mismatch = hs & (elem_i != exp_q);
        rx_inc   = (rx_q == '1) ? rx_q : rx_q + CNT_ONE;
        errc_inc = (errc_q == '1) ? errc_q : errc_q + CNT_ONE;
        lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        // Compare against the saturated count, so that len = all-ones ends
        // the run on the handshake that saturates the counter.
        last_hs  = hs && (len_q != '0) && (rx_inc == len_q);
    end

    // Next-state logic. An abort wins over the final handshake; the element
    // in that cycle is still counted by the datapath below.
    always_comb begin
        state_d    = state_q;
        start_load = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d    = ST_RUN;
                    start_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (last_hs) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= ST_IDLE;
            lfsr_q  <= LFSR_INIT;
            exp_q   <= '0;
            len_q   <= '0;
            rx_q    <= '0;
            errc_q  <= '0;
            err_q   <= 1'b0;
            fgot_q  <= '0;
            fexp_q  <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_RUN) begin
                lfsr_q <= {lfsr_q[6:0], lfsr_fb};
            end

            // A start is only accepted outside RUN and a handshake only
            // happens in RUN, so the two branches never compete.
            if (start_load) begin
                exp_q  <= exp_seed_i;
                len_q  <= len_i;
                rx_q   <= '0;
                errc_q <= '0;
                err_q  <= 1'b0;
                fgot_q <= '0;
                fexp_q <= '0;
            end else if (hs) begin
                rx_q  <= rx_inc;
                exp_q <= exp_q + ELEM_ONE;
                if (mismatch) begin
                    errc_q <= errc_inc;
                    err_q  <= 1'b1;
                    if (!err_q) begin
                        fgot_q <= elem_i;
                        fexp_q <= exp_q;
                    end
                end
            end
        end
    end

    always_comb begin
        rx_count_o      = rx_q;
        err_count_o     = errc_q;
        err_o           = err_q;
        first_err_got_o = fgot_q;
        first_err_exp_o = fexp_q;
        busy_o          = (state_q == ST_RUN);
        done_o          = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_elem_stream_checker.sv
// Self-checking bench for elem_stream_checker. A vector table covers the
// clean run and the single-error run; hand-written sequences cover throttle,
// stop/reset, saturation (on a CNT_WIDTH=4 instance) and restart.
module tb_elem_stream_checker;

    logic        clk = 1'b0;
    logic        srst = 1'b0;
    logic [3:0]  elem = '0;
    logic        valid = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        thr = 1'b0;
    logic [3:0]  seed = '0;
    logic [15:0] len = '0;

    logic        ready, err, busy, done;
    logic [15:0] rx, errc;
    logic [3:0]  fg, fe;

    logic        start4 = 1'b0;
    logic        stop4 = 1'b0;
    logic [3:0]  len4 = '0;
    logic        ready4, err4, busy4, done4;
    logic [3:0]  rx4, errc4, fg4, fe4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    elem_stream_checker #(
        .ELEM_WIDTH(4),
        .CNT_WIDTH (16),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .elem_i         (elem),
        .elem_valid_i   (valid),
        .elem_ready_o   (ready),
        .start_i        (start),
        .stop_i         (stop),
        .throttle_en_i  (thr),
        .exp_seed_i     (seed),
        .len_i          (len),
        .rx_count_o     (rx),
        .err_count_o    (errc),
        .err_o          (err),
        .first_err_got_o(fg),
        .first_err_exp_o(fe),
        .busy_o         (busy),
        .done_o         (done)
    );

    elem_stream_checker #(
        .ELEM_WIDTH(4),
        .CNT_WIDTH (4),
        .LFSR_SEED (8'hA5)
    ) dut4 (
        .clk_i          (clk),
        .srst_i         (srst),
        .elem_i         (elem),
        .elem_valid_i   (valid),
        .elem_ready_o   (ready4),
        .start_i        (start4),
        .stop_i         (stop4),
        .throttle_en_i  (thr),
        .exp_seed_i     (seed),
        .len_i          (len4),
        .rx_count_o     (rx4),
        .err_count_o    (errc4),
        .err_o          (err4),
        .first_err_got_o(fg4),
        .first_err_exp_o(fe4),
        .busy_o         (busy4),
        .done_o         (done4)
    );

    typedef struct {
        logic [3:0]  elem;
        logic        valid;
        logic        start;
        logic [3:0]  seed;
        logic [15:0] len;
        logic        x_ready;
        logic        x_busy;
        logic        x_done;
        int          x_rx;
        int          x_errc;
        logic        x_err;
    } vec_t;

    vec_t vecs [0:43];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Advance one clock; return at the following falling edge, where outputs
    // are sampled and new inputs are driven.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        srst = 1'b1;
        step();
        step();
        srst = 1'b0;
    endtask

    function automatic vec_t mkvec(int base, int k);
        vec_t v;
        // base 0: clean run; base 22: run with element 5 replaced by 9
        v.elem    = 4'((3 + k - 1) % 16);
        v.valid   = (k >= 1 && k <= 20);
        v.start   = (k == 0);
        v.seed    = 4'd3;
        v.len     = 16'd20;
        v.x_ready = (k >= 1 && k <= 20);
        v.x_busy  = (k >= 1 && k <= 20);
        v.x_done  = (k == 21) || (base == 22 && k == 0);
        v.x_rx    = (k == 0) ? ((base == 22) ? 20 : 0) : (k - 1);
        v.x_errc  = 0;
        v.x_err   = 1'b0;
        if (k == 0) v.elem = 4'd0;
        if (k == 21) v.elem = 4'd0;
        if (base == 22) begin
            if (k == 5) v.elem = 4'd9;
            if (k >= 6) begin
                v.x_errc = 1;
                v.x_err  = 1'b1;
            end
        end
        return v;
    endfunction

    initial begin
        logic [7:0] m;
        int         cnt;

        for (int k = 0; k < 22; k++) begin
            vecs[k]      = mkvec(0, k);
            vecs[22 + k] = mkvec(22, k);
        end

        @(negedge clk);
        do_reset();

        // Reset state of both instances
        chk("rst ready", ready, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst rx", rx, 0);
        chk("rst errc", errc, 0);
        chk("rst fg", fg, 0);
        chk("rst fe", fe, 0);
        chk("rst4 rx", rx4, 0);
        chk("rst4 busy", busy4, 0);

        // Tests 1 and 2: clean run, then a run with a single error
        for (int i = 0; i < 44; i++) begin
            chk($sformatf("v%0d ready", i), ready, vecs[i].x_ready);
            chk($sformatf("v%0d busy", i), busy, vecs[i].x_busy);
            chk($sformatf("v%0d done", i), done, vecs[i].x_done);
            chk($sformatf("v%0d rx", i), rx, vecs[i].x_rx);
            chk($sformatf("v%0d errc", i), errc, vecs[i].x_errc);
            chk($sformatf("v%0d err", i), err, vecs[i].x_err);
            elem  = vecs[i].elem;
            valid = vecs[i].valid;
            start = vecs[i].start;
            seed  = vecs[i].seed;
            len   = vecs[i].len;
            step();
        end
        chk("t2 first got", fg, 9);
        chk("t2 first exp", fe, 7);

        // Test 3: throttle against a bit-accurate LFSR model
        do_reset();
        thr = 1'b1; start = 1'b1; seed = 4'd0; len = 16'd0;
        step();
        start = 1'b0; valid = 1'b1; elem = 4'd0;
        m = 8'hA5;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            chk($sformatf("t3 ready c%0d", c), ready, m[0]);
            if (m[0]) cnt++;
            step();
            m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
        end
        chk("t3 rx", rx, cnt);
        valid = 1'b0; thr = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t3 stop busy", busy, 0);

        // Test 4: stop with a simultaneous handshake, then reset mid-run
        start = 1'b1; seed = 4'd0; len = 16'd0;
        step();
        start = 1'b0; valid = 1'b1;
        for (int e = 0; e < 3; e++) begin
            elem = 4'(e);
            step();
        end
        elem = 4'd3; stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t4 rx", rx, 4);
        chk("t4 errc", errc, 0);
        chk("t4 busy", busy, 0);
        chk("t4 done", done, 0);
        chk("t4 ready", ready, 0);
        step();
        step();
        chk("t4 rx held", rx, 4);
        start = 1'b1; valid = 1'b0;
        step();
        start = 1'b0; valid = 1'b1; elem = 4'd0;
        step();
        elem = 4'd5;
        step();
        chk("t4 run rx", rx, 2);
        chk("t4 run err", err, 1);
        elem = 4'd2; srst = 1'b1;
        step();
        srst = 1'b0; valid = 1'b0;
        chk("t4 srst ready", ready, 0);
        chk("t4 srst busy", busy, 0);
        chk("t4 srst done", done, 0);
        chk("t4 srst err", err, 0);
        chk("t4 srst rx", rx, 0);
        chk("t4 srst errc", errc, 0);
        chk("t4 srst fg", fg, 0);
        chk("t4 srst fe", fe, 0);

        // Test 5: unbounded run with saturation on the CNT_WIDTH=4 instance
        start4 = 1'b1; len4 = 4'd0; seed = 4'd0;
        step();
        start4 = 1'b0; valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            elem = 4'((i + 1) % 16);
            step();
        end
        valid = 1'b0;
        chk("t5 rx4", rx4, 15);
        chk("t5 errc4", errc4, 15);
        chk("t5 busy4", busy4, 1);
        chk("t5 fg4", fg4, 1);
        chk("t5 fe4", fe4, 0);
        chk("t5 idle rx", rx, 0);
        stop4 = 1'b1;
        step();
        stop4 = 1'b0;
        chk("t5 stop busy4", busy4, 0);
        // len = all-ones ends on the saturating handshake
        start4 = 1'b1; len4 = 4'd15; seed = 4'd0;
        step();
        start4 = 1'b0; valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            elem = 4'(i);
            step();
        end
        valid = 1'b0;
        chk("t5 max done4", done4, 1);
        chk("t5 max rx4", rx4, 15);
        chk("t5 max errc4", errc4, 0);

        // Test 6: restart from DONE clears everything
        start = 1'b1; seed = 4'd5; len = 16'd3;
        step();
        start = 1'b0; valid = 1'b1;
        elem = 4'd5; step();
        elem = 4'd0; step();
        elem = 4'd7; step();
        valid = 1'b0;
        chk("t6 done", done, 1);
        chk("t6 errc", errc, 1);
        chk("t6 fg", fg, 0);
        chk("t6 fe", fe, 6);
        start = 1'b1; seed = 4'd0; len = 16'd4;
        step();
        start = 1'b0;
        chk("t6 rs rx", rx, 0);
        chk("t6 rs errc", errc, 0);
        chk("t6 rs err", err, 0);
        chk("t6 rs fe", fe, 0);
        chk("t6 rs busy", busy, 1);
        chk("t6 rs ready", ready, 1);
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            elem = 4'(i);
            step();
        end
        valid = 1'b0;
        chk("t6 end done", done, 1);
        chk("t6 end rx", rx, 4);
        chk("t6 end errc", errc, 0);
        chk("t6 end err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/elem_stream_checker.md
# elem_stream_checker

Single-clock receiving end of the element valid/ready stream, sitting on the consumer side of the `cdc_fifo` output (`elem_out_*`). It accepts elements, compares each one against an expected incrementing sequence, and counts received elements and mismatches. It optionally throttles `elem_ready_o` with an LFSR pattern to exercise back-pressure. It is used as the self-checking sink in FIFO and pipeline bring-up.

## Interface
- `ELEM_WIDTH`, default 4: element width in bits.
- `CNT_WIDTH`, default 16: width of the length, received-count and error-count fields.
- `LFSR_SEED`, default 8'hA5: throttle LFSR reset value. A value of 0 is replaced by 8'h01.
- `clk_i`  in  1: the single clock; all logic is on its rising edge.
- `srst_i`  in  1: synchronous, active-high reset.
- `elem_i`  in  ELEM_WIDTH: incoming element.
- `elem_valid_i`  in  1: element valid.
- `elem_ready_o`  out  1: checker ready to accept.
- `start_i`  in  1: one-cycle pulse that begins a check run.
- `stop_i`  in  1: one-cycle pulse that aborts a run.
- `throttle_en_i`  in  1: 1 = ready follows the LFSR; 0 = ready is constant 1 in RUN.
- `exp_seed_i`  in  ELEM_WIDTH: first expected element, sampled on start.
- `len_i`  in  CNT_WIDTH: number of elements per run, sampled on start. 0 = unbounded.
- `rx_count_o`  out  CNT_WIDTH: accepted-element count.
- `err_count_o`  out  CNT_WIDTH: mismatch count.
- `err_o`  out  1: sticky flag, set on any mismatch in the run.
- `first_err_got_o`  out  ELEM_WIDTH: received value at the first mismatch.
- `first_err_exp_o`  out  ELEM_WIDTH: expected value at the first mismatch.
- `busy_o`  out  1: high in RUN.
- `done_o`  out  1: high in DONE.

## Operation
- **States:** IDLE, RUN, DONE.
  - IDLE → RUN on `start_i`.
  - RUN → IDLE on `stop_i`.
  - RUN → DONE on the handshake that makes `rx_count` equal a non-zero `len`.
  - DONE → RUN on `start_i`.
  - `start_i` is ignored in RUN.
- **Start:** loads `exp` ← `exp_seed_i` and `len` ← `len_i`. Clears `rx_count_o`, `err_count_o`, `err_o`, `first_err_got_o` and `first_err_exp_o`.
- **Ready:**
  - `elem_ready_o` = (state==RUN) & (`throttle_en_i` ? `lfsr[0]` : 1).
  - It depends only on registered state and `throttle_en_i`, never on `elem_valid_i`.
- **Handshake:** `elem_valid_i & elem_ready_o` in a cycle. Nothing else is counted.
- **On each handshake:**
  - `rx_count` += 1, saturating at all-ones.
  - Compare `elem_i` with `exp`, then `exp` ← `exp`+1, wrapping mod 2^ELEM_WIDTH. `exp` always advances, whether or not the element matched; there is no resync.
- **On a mismatch:**
  - `err_count` += 1, saturating.
  - `err_o` ← 1.
  - If this is the first error of the run, capture `elem_i` into `first_err_got_o` and `exp` into `first_err_exp_o`.
- **LFSR:**
  - 8-bit Fibonacci, feedback = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3], shifted left with the feedback into bit 0.
  - Advances every cycle in RUN and holds otherwise.
  - Reloads `LFSR_SEED` on reset only, not on start.
- **Values outside RUN:** counters, flags and captures hold their values in IDLE and DONE until the next start or reset.

## Timing
- **Reset values:**
  - state = IDLE.
  - `elem_ready_o`, `busy_o`, `done_o`, `err_o` = 0.
  - `rx_count_o`, `err_count_o`, `first_err_*` = 0.
  - exp = 0, lfsr = `LFSR_SEED` (or 8'h01 if the seed is 0).
- **Reset mid-run:** `srst_i` in RUN forces the reset values on the next edge. A handshake in that same cycle is dropped.
- **Start latency:** `start_i` at edge N gives `busy_o`=1 and `elem_ready_o` possible from cycle N+1.
- **Count latency:** a handshake at edge N is reflected in `rx_count_o`, `err_count_o` and `err_o` after edge N. That is one cycle of latency, with all outputs registered.
- **Run end (len ≠ 0):** the final handshake at edge N gives `done_o`=1 and `busy_o`=0, and `elem_ready_o`=0 from cycle N+1.
- **Stop with a handshake:** a handshake in the same cycle as `stop_i` is counted and checked, then the state goes to IDLE.
- **Start and stop together in IDLE/DONE:** `start_i` wins, since `stop_i` has no effect outside RUN.
- **Saturation:** `rx_count` saturates at 2^CNT_WIDTH−1.
  - With `len`=0 the run continues after saturation.
  - With `len` = all-ones, DONE is reached on the saturating handshake.
- **Valid without ready:** `elem_valid_i` held high while ready is low has no effect. The element is neither counted nor checked.

## Test plan
1. **Clean run.** Reset, then start with seed=3, len=20, throttle=0, and the source sends 3,4,…,15,0,1,…,6 with continuous valid.
   - Ready stays high for all 20 cycles.
   - `rx_count_o`=20, `err_count_o`=0, `err_o`=0.
   - `done_o`=1 one cycle after the 20th handshake.
   - Also checks wrap 15→0.
2. **Single error.** Same as 1, but the 5th element is 9 instead of 7.
   - `err_count_o`=1, `err_o`=1.
   - `first_err_got_o`=9, `first_err_exp_o`=7.
   - The following elements 8,9,… produce no further errors.
3. **Throttle.** throttle=1 with `LFSR_SEED`=8'hA5 and valid always high.
   - Ready matches a bit-accurate model of lfsr[0].
   - After 40 cycles, `rx_count_o` equals the number of ready-high cycles in RUN.
4. **Stop and reset.** Stop with a simultaneous handshake mid-run.
   - That element is counted, then state is IDLE with counts held.
   - Next, `srst_i` during RUN: all outputs are 0 the following cycle.
5. **Unbounded and saturation.** len=0 with CNT_WIDTH overridden to 4, and 20 mismatching elements.
   - `rx_count_o`=15 and `err_count_o`=15, both saturated.
   - `busy_o` stays 1.
6. **Restart.** `start_i` in DONE with seed=0.
   - All counts and the sticky flag are cleared, and checking restarts from 0.
